// File: rtl/cache_pkg.sv
// Shared widths, FSM state codes and way-select helpers for the 2-way cache miss controller.
package cache_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned TAG_W  = ADDR_W - IDX_W;
    localparam int unsigned SETS   = 2 ** IDX_W;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned ST_W   = 3;

    localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] ST_LOOKUP = 3'd1;
    localparam logic [ST_W-1:0] ST_WB     = 3'd2;
    localparam logic [ST_W-1:0] ST_FETCH  = 3'd3;
    localparam logic [ST_W-1:0] ST_FILL   = 3'd4;

    typedef logic way_t;
    localparam way_t WAY0 = 1'b0;
    localparam way_t WAY1 = 1'b1;

    function automatic logic [1:0] way_onehot(input way_t w);
        return (w == WAY1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/cache_lru.sv
// Per-set LRU bits: each bit names the way to evict next; an access marks the other way.
module cache_lru
    import cache_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_index,
    output way_t             victim_c,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_index,
    input  way_t             upd_way
);

    logic [SETS-1:0] lru;

    assign victim_c = lru[rd_index];

    always_ff @(posedge clock) begin
        if (reset) begin
            lru <= '0;
        end else if (upd_en) begin
            lru[upd_index] <= ~upd_way;
        end
    end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Write-back / write-allocate controller for a 2-way set-associative cache.
// Optional statistics counters are built when CACHE_STATS_EN is defined.
module cache_miss_ctrl
    import cache_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic [1:0]        way_valid,
    input  logic [1:0]        way_dirty,
    input  logic [TAG_W-1:0]  way_tag0,
    input  logic [TAG_W-1:0]  way_tag1,
    input  logic [DATA_W-1:0] way_data0,
    input  logic [DATA_W-1:0] way_data1,
    output logic [IDX_W-1:0]  arr_index,
    output logic [1:0]        fill_we,
    output logic [TAG_W-1:0]  fill_tag,
    output logic [DATA_W-1:0] fill_data,
    output logic              fill_dirty,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    logic [ST_W-1:0]   state, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wren_q, wren_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    way_t              victim_q, victim_d;
    logic [TAG_W-1:0]  vic_tag_q, vic_tag_d;
    logic [DATA_W-1:0] vic_data_q, vic_data_d, mdata_q, mdata_d;

    logic [IDX_W-1:0]  arr_index_d;
    logic              cpu_ready_d, fill_dirty_d, mem_req_d, mem_we_d;
    logic [DATA_W-1:0] cpu_rdata_d, fill_data_d, mem_wdata_d;
    logic [1:0]        fill_we_d;
    logic [TAG_W-1:0]  fill_tag_d;
    logic [ADDR_W-1:0] mem_addr_d;

    logic [TAG_W-1:0]  tag_q;
    logic [IDX_W-1:0]  idx_q;
    logic              hit0, hit1, hit;
    way_t              hit_way, miss_way, lru_victim_c, lru_way;
    logic              lru_upd;

    assign tag_q = addr_q[ADDR_W-1:IDX_W];
    assign idx_q = addr_q[IDX_W-1:0];

    // A double tag match cannot happen in a consistent array; way0 takes it if it does.
    assign hit0     = way_valid[0] && (way_tag0 == tag_q);
    assign hit1     = way_valid[1] && (way_tag1 == tag_q);
    assign hit      = hit0 || hit1;
    assign hit_way  = hit0 ? WAY0 : WAY1;
    assign miss_way = !way_valid[0] ? WAY0 : (!way_valid[1] ? WAY1 : lru_victim_c);

    cache_lru u_lru (
        .clock     (clock),
        .reset     (reset),
        .rd_index  (idx_q),
        .victim_c  (lru_victim_c),
        .upd_en    (lru_upd),
        .upd_index (idx_q),
        .upd_way   (lru_way)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_d;
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d      = state;
        addr_d       = addr_q;
        wren_d       = wren_q;
        wdata_d      = wdata_q;
        victim_d     = victim_q;
        vic_tag_d    = vic_tag_q;
        vic_data_d   = vic_data_q;
        mdata_d      = mdata_q;
        arr_index_d  = arr_index;
        cpu_ready_d  = 1'b0;
        cpu_rdata_d  = cpu_rdata;
        fill_we_d    = 2'b00;
        fill_tag_d   = fill_tag;
        fill_data_d  = fill_data;
        fill_dirty_d = fill_dirty;
        mem_req_d    = 1'b0;
        mem_we_d     = mem_we;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        lru_upd      = 1'b0;
        lru_way      = WAY0;

        case (state)
            ST_IDLE: begin
                // cpu_req is still high during the ready cycle; wait for the next one.
                if (cpu_req && !cpu_ready) begin
                    addr_d      = cpu_addr;
                    wren_d      = cpu_wren;
                    wdata_d     = cpu_wdata;
                    arr_index_d = cpu_addr[IDX_W-1:0];
                    state_d     = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (hit) begin
                    lru_upd     = 1'b1;
                    lru_way     = hit_way;
                    cpu_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                    if (wren_q) begin
                        fill_we_d    = way_onehot(hit_way);
                        fill_tag_d   = tag_q;
                        fill_data_d  = wdata_q;
                        fill_dirty_d = 1'b1;
                    end else begin
                        cpu_rdata_d = (hit_way == WAY1) ? way_data1 : way_data0;
                    end
                end else begin
                    victim_d   = miss_way;
                    vic_tag_d  = (miss_way == WAY1) ? way_tag1 : way_tag0;
                    vic_data_d = (miss_way == WAY1) ? way_data1 : way_data0;
                    state_d    = (way_valid[miss_way] && way_dirty[miss_way]) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB: begin
                if (!mem_req) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {vic_tag_q, idx_q};
                    mem_wdata_d = vic_data_q;
                end else if (mem_ack) begin
                    state_d = ST_FETCH;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            ST_FETCH: begin
                if (!mem_req) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = addr_q;
                end else if (mem_ack) begin
                    mdata_d = mem_rdata;
                    state_d = ST_FILL;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            ST_FILL: begin
                fill_we_d    = way_onehot(victim_q);
                fill_tag_d   = tag_q;
                fill_data_d  = wren_q ? wdata_q : mdata_q;
                fill_dirty_d = wren_q;
                cpu_ready_d  = 1'b1;
                if (!wren_q) cpu_rdata_d = mdata_q;
                lru_upd      = 1'b1;
                lru_way      = victim_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q     <= '0;
            wren_q     <= 1'b0;
            wdata_q    <= '0;
            victim_q   <= WAY0;
            vic_tag_q  <= '0;
            vic_data_q <= '0;
            mdata_q    <= '0;
            arr_index  <= '0;
            cpu_ready  <= 1'b0;
            cpu_rdata  <= '0;
            fill_we    <= 2'b00;
            fill_tag   <= '0;
            fill_data  <= '0;
            fill_dirty <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            addr_q     <= addr_d;
            wren_q     <= wren_d;
            wdata_q    <= wdata_d;
            victim_q   <= victim_d;
            vic_tag_q  <= vic_tag_d;
            vic_data_q <= vic_data_d;
            mdata_q    <= mdata_d;
            arr_index  <= arr_index_d;
            cpu_ready  <= cpu_ready_d;
            cpu_rdata  <= cpu_rdata_d;
            fill_we    <= fill_we_d;
            fill_tag   <= fill_tag_d;
            fill_data  <= fill_data_d;
            fill_dirty <= fill_dirty_d;
            mem_req    <= mem_req_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
        end
    end

`ifdef CACHE_STATS_EN
    logic stat_hit, stat_miss;
    assign stat_hit  = (state == ST_LOOKUP) && hit;
    assign stat_miss = (state == ST_LOOKUP) && !hit;

    // Saturating lookup statistics.
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (stat_hit && (hit_cnt != '1))   hit_cnt  <= hit_cnt + CNT_W'(1);
            if (stat_miss && (miss_cnt != '1)) miss_cnt <= miss_cnt + CNT_W'(1);
        end
    end
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Randomized bench for cache_miss_ctrl: array and memory environment plus a behavioural cache model.
module tb_cache_miss_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_wren;
    logic [4:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_ready;
    logic [7:0] cpu_rdata;
    logic [1:0] way_valid, way_dirty;
    logic [2:0] way_tag0, way_tag1;
    logic [7:0] way_data0, way_data1;
    logic [1:0] arr_index;
    logic [1:0] fill_we;
    logic [2:0] fill_tag;
    logic [7:0] fill_data;
    logic       fill_dirty;
    logic       mem_req, mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic [7:0] hit_cnt, miss_cnt;

    always #5 clock = ~clock;

    cache_miss_ctrl dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .way_valid(way_valid), .way_dirty(way_dirty),
        .way_tag0(way_tag0), .way_tag1(way_tag1), .way_data0(way_data0), .way_data1(way_data1),
        .arr_index(arr_index), .fill_we(fill_we), .fill_tag(fill_tag), .fill_data(fill_data),
        .fill_dirty(fill_dirty),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    // Cache arrays: read of the index the controller drives, write on fill_we.
    logic       a_valid [4][2] = '{default: '0};
    logic       a_dirty [4][2] = '{default: '0};
    logic [2:0] a_tag   [4][2] = '{default: '0};
    logic [7:0] a_data  [4][2] = '{default: '0};
    int         fill_cnt = 0;
    int         both_cnt = 0;
    logic       f_way, f_dirty;
    logic [2:0] f_tag;
    logic [7:0] f_data;

    always_comb begin
        way_valid = {a_valid[arr_index][1], a_valid[arr_index][0]};
        way_dirty = {a_dirty[arr_index][1], a_dirty[arr_index][0]};
        way_tag0  = a_tag[arr_index][0];
        way_tag1  = a_tag[arr_index][1];
        way_data0 = a_data[arr_index][0];
        way_data1 = a_data[arr_index][1];
    end

    always @(posedge clock) begin
        if (fill_we != 2'b00) begin
            a_valid[arr_index][fill_we[1]] <= 1'b1;
            a_dirty[arr_index][fill_we[1]] <= fill_dirty;
            a_tag[arr_index][fill_we[1]]   <= fill_tag;
            a_data[arr_index][fill_we[1]]  <= fill_data;
            fill_cnt <= fill_cnt + 1;
            f_way    <= fill_we[1];
            f_tag    <= fill_tag;
            f_data   <= fill_data;
            f_dirty  <= fill_dirty;
            if (fill_we == 2'b11) both_cnt <= both_cnt + 1;
        end
    end

    // Main memory with configurable ack latency; every completed transfer is logged in order.
    typedef struct packed { logic we; logic [4:0] addr; logic [7:0] data; } mev_t;
    mev_t       mlog[$];
    logic [7:0] mem [32];
    int         lat_fixed = 0;
    bit         rst_test  = 0;

    initial begin
        int         lat;
        bit         gone;
        logic [4:0] a0;
        logic       w0;
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clock);
            mem_ack = 1'b0;
            if (mem_req && !reset) begin
                lat  = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4));
                a0   = mem_addr;
                w0   = mem_we;
                gone = 0;
                for (int k = 1; k < lat; k++) begin
                    @(negedge clock);
                    if (rst_test && !mem_req) begin
                        gone = 1;
                        break;
                    end
                    check("mem_req_held", mem_req, 1);
                    check("mem_addr_steady", mem_addr, a0);
                    check("no_early_ready", cpu_ready, 0);
                end
                if (!gone) begin
                    mem_ack = 1'b1;
                    mlog.push_back('{w0, a0, mem_wdata});
                    if (w0) mem[a0] = mem_wdata;
                    else    mem_rdata = mem[a0];
                end
            end
        end
    end

    // Behavioural model: architectural memory image plus per-set residency with access times.
    logic [7:0] gold [32];
    logic       mv [4][2];
    logic       md [4][2];
    logic [2:0] mt [4][2];
    int         mtime [4][2];
    int         now = 10;
    int         m_hits = 0;
    int         m_miss = 0;

    task automatic check_stats();
        int eh, em;
`ifdef CACHE_STATS_EN
        eh = (m_hits > 255) ? 255 : m_hits;
        em = (m_miss > 255) ? 255 : m_miss;
`else
        eh = 0;
        em = 0;
`endif
        check("hit_cnt", hit_cnt, eh);
        check("miss_cnt", miss_cnt, em);
    endtask

    task automatic do_access(input logic wr, input logic [4:0] addr, input logic [7:0] wd);
        logic [1:0] s;
        logic [2:0] t;
        logic       h0, h1, hit, w, wb;
        logic [4:0] wba;
        int         cyc, fb, nexp;
        mev_t       ev;
        s   = addr[1:0];
        t   = addr[4:2];
        h0  = mv[s][0] && (mt[s][0] == t);
        h1  = mv[s][1] && (mt[s][1] == t);
        hit = h0 || h1;
        if (hit)            w = h1 && !h0;
        else if (!mv[s][0]) w = 1'b0;
        else if (!mv[s][1]) w = 1'b1;
        else                w = (mtime[s][1] < mtime[s][0]);
        wb   = !hit && mv[s][w] && md[s][w];
        wba  = {mt[s][w], s};
        nexp = wb ? 2 : 1;
        mlog.delete();
        fb = fill_cnt;

        @(negedge clock);
        cpu_req = 1'b1; cpu_wren = wr; cpu_addr = addr; cpu_wdata = wd;
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (!cpu_ready && cyc < 200);
        check("cpu_ready", cpu_ready, 1);
        if (!wr) check("rdata", cpu_rdata, gold[addr]);
        cpu_req = 1'b0; cpu_wren = 1'b0;
        @(posedge clock);
        #1;

        if (hit) begin
            check("hit_latency", cyc, 2);
            check("hit_no_mem", mlog.size(), 0);
        end else begin
            check("mem_events", mlog.size(), nexp);
            if (wb && mlog.size() >= 1) begin
                ev = mlog[0];
                check("wb_we", ev.we, 1);
                check("wb_addr", ev.addr, wba);
                check("wb_data", ev.data, gold[wba]);
            end
            if (mlog.size() == nexp) begin
                ev = mlog[nexp-1];
                check("fetch_we", ev.we, 0);
                check("fetch_addr", ev.addr, addr);
            end
        end
        if (hit && !wr) begin
            check("no_fill", fill_cnt - fb, 0);
        end else begin
            check("fill_count", fill_cnt - fb, 1);
            check("fill_way", f_way, w);
            check("fill_tag", f_tag, t);
            check("fill_dirty", f_dirty, wr);
            check("fill_data", f_data, wr ? wd : gold[addr]);
        end

        if (wr) gold[addr] = wd;
        md[s][w]    = hit ? (md[s][w] | wr) : wr;
        mv[s][w]    = 1'b1;
        mt[s][w]    = t;
        now++;
        mtime[s][w] = now;
        if (hit) m_hits++;
        else     m_miss++;
        check_stats();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, fb;
        reset = 1'b1; cpu_req = 1'b0; cpu_wren = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        for (int s = 0; s < 4; s++) begin
            for (int w = 0; w < 2; w++) begin
                mv[s][w] = 1'b0; md[s][w] = 1'b0; mt[s][w] = '0; mtime[s][w] = w;
            end
        end
        repeat (3) @(negedge clock);
        for (int i = 0; i < 32; i++) gold[i] = mem[i];
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_fill_we", fill_we, 0);
        check("rst_arr_index", arr_index, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_fill_data", fill_data, 0);
        check_stats();
        reset = 1'b0;

        // Cold miss, re-read hit, write hit, then same-set fills and a dirty eviction.
        do_access(1'b0, 5'h05, 8'h00);
        do_access(1'b0, 5'h05, 8'h00);
        do_access(1'b1, 5'h05, 8'hA5);
        do_access(1'b0, 5'h09, 8'h00);
        do_access(1'b0, 5'h0D, 8'h00);

        // Slow memory: requests must stay steady for five cycles.
        lat_fixed = 5;
        do_access(1'b0, 5'h02, 8'h00);
        do_access(1'b1, 5'h06, 8'h3C);
        do_access(1'b0, 5'h0A, 8'h00);
        do_access(1'b0, 5'h0E, 8'h00);

        // Reset during FETCH after steering the set-1 LRU toward way1.
        lat_fixed = 0;
        do_access(1'b0, 5'h01, 8'h00);
        do_access(1'b0, 5'h05, 8'h00);
        do_access(1'b0, 5'h05, 8'h00);
        lat_fixed = 20;
        rst_test  = 1;
        @(negedge clock);
        cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 5'h09;
        cyc = 0;
        while (!(mem_req && !mem_we) && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        check("reached_fetch", mem_req && !mem_we, 1);
        fb      = fill_cnt;
        reset   = 1'b1;
        cpu_req = 1'b0;
        @(negedge clock);
        check("abort_mem_req", mem_req, 0);
        check("abort_mem_we", mem_we, 0);
        check("abort_fill_we", fill_we, 0);
        check("abort_cpu_ready", cpu_ready, 0);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("abort_no_fill", fill_cnt - fb, 0);
        check("abort_idle_mem", mem_req, 0);
        lat_fixed = 0;
        rst_test  = 0;
        for (int s = 0; s < 4; s++) begin
            mtime[s][0] = 0;
            mtime[s][1] = 1;
        end
        m_hits = 0;
        m_miss = 0;
        check_stats();
        do_access(1'b0, 5'h0D, 8'h00);

        // Long hit run for counter saturation.
        repeat (300) do_access(1'b0, 5'h0D, 8'h00);

        // Random traffic with random memory latency.
        repeat (250) do_access(1'($urandom), 5'($urandom), 8'($urandom));

        check("fill_we_onehot", both_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
